// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and FSM state type for the hazard/stall sequencer.
package hazard_stall_ctrl_pkg;

  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int HZ_STATE_LEN      = 2;

  // RUN=0, MEM_WAIT=1, ERR=2; the unused code 3 is treated as ERR.
  typedef enum logic [HZ_STATE_LEN-1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERR      = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/stall sequencer.
// master = pipeline side (drives hazard inputs), slave = sequencer side.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  fwd_en;
  logic [REG_ADDR_W-1:0] src1_ID;
  logic [REG_ADDR_W-1:0] src2_ID;
  logic                  two_src_ID;
  logic [REG_ADDR_W-1:0] dest_EXE;
  logic                  WB_EN_EXE;
  logic                  MEM_R_EN_EXE;
  logic [REG_ADDR_W-1:0] dest_MEM;
  logic                  WB_EN_MEM;
  logic                  branch_taken_EXE;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  freeze_PC;
  logic                  freeze_IF_ID;
  logic                  bubble_ID_EXE;
  logic                  flush_IF_ID;
  logic                  stall_all;
  logic                  timeout_err;

  modport master (
    output fwd_en, src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE,
           MEM_R_EN_EXE, dest_MEM, WB_EN_MEM, branch_taken_EXE, mem_req, mem_ready,
    input  freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, stall_all, timeout_err
  );

  modport slave (
    input  fwd_en, src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE,
           MEM_R_EN_EXE, dest_MEM, WB_EN_MEM, branch_taken_EXE, mem_req, mem_ready,
    output freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, stall_all, timeout_err
  );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational hazard detector: load-use always, any RAW when forwarding is off.
module hazard_stall_ctrl_hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  fwd_en_i,
  input  logic [REG_ADDR_W-1:0] src1_i,
  input  logic [REG_ADDR_W-1:0] src2_i,
  input  logic                  two_src_i,
  input  logic [REG_ADDR_W-1:0] dest_exe_i,
  input  logic                  wb_en_exe_i,
  input  logic                  mem_r_en_exe_i,
  input  logic [REG_ADDR_W-1:0] dest_mem_i,
  input  logic                  wb_en_mem_i,
  output logic                  hazard_o
);

  // r0 is never a real dependency; src2 only counts when the instruction reads it.
  function automatic logic dest_match(input logic [REG_ADDR_W-1:0] dest);
    return (dest != '0) && ((src1_i == dest) || (two_src_i && (src2_i == dest)));
  endfunction

  logic hz_lu_s;
  logic hz_nofwd_s;

  // Hazard classification from the ID sources against EXE/MEM destinations.
  always_comb begin
    hz_lu_s    = mem_r_en_exe_i & wb_en_exe_i & dest_match(dest_exe_i);
    hz_nofwd_s = ~fwd_en_i & ((wb_en_exe_i & dest_match(dest_exe_i)) |
                              (wb_en_mem_i & dest_match(dest_mem_i)));
    hazard_o   = hz_lu_s | hz_nofwd_s;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: hazard freezes, branch flushes (deferred
// across memory waits), whole-pipeline stall during data-memory waits and a
// sticky timeout error. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_FILE_ADDR_LEN,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          lu_stall_cnt,
  output logic [31:0]          mem_stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  hz_state_e           state_q, state_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic                hazard_s;
  logic                freeze_s, bubble_s, flush_s, stall_s, err_s;

  hazard_stall_ctrl_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .fwd_en_i       (bus.fwd_en),
    .src1_i         (bus.src1_ID),
    .src2_i         (bus.src2_ID),
    .two_src_i      (bus.two_src_ID),
    .dest_exe_i     (bus.dest_EXE),
    .wb_en_exe_i    (bus.WB_EN_EXE),
    .mem_r_en_exe_i (bus.MEM_R_EN_EXE),
    .dest_mem_i     (bus.dest_MEM),
    .wb_en_mem_i    (bus.WB_EN_MEM),
    .hazard_o       (hazard_s)
  );

  // Next-state and Mealy outputs; memory stall outranks flush, flush outranks hazard.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    flush_pend_d = flush_pend_q;
    freeze_s     = 1'b0;
    bubble_s     = 1'b0;
    flush_s      = 1'b0;
    stall_s      = 1'b0;
    err_s        = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          stall_s      = 1'b1;
          state_d      = HZ_MEM_WAIT;
          to_cnt_d     = TO_CNT_W'(1);
          flush_pend_d = bus.branch_taken_EXE;
        end else if (bus.branch_taken_EXE || flush_pend_q) begin
          // The ID instruction is discarded, so no freeze is needed.
          flush_s      = 1'b1;
          bubble_s     = 1'b1;
          flush_pend_d = 1'b0;
        end else if (hazard_s) begin
          freeze_s     = 1'b1;
          bubble_s     = 1'b1;
        end else begin
          freeze_s     = 1'b0;
        end
      end
      HZ_MEM_WAIT: begin
        stall_s      = 1'b1;
        flush_pend_d = flush_pend_q | bus.branch_taken_EXE;
        if (bus.mem_ready) begin
          stall_s  = 1'b0;
          state_d  = HZ_RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_CNT_W'(MEM_TIMEOUT)) begin
          state_d  = HZ_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end
      default: begin
        // ERR and the unused encoding: locked until reset.
        stall_s = 1'b1;
        err_s   = 1'b1;
        state_d = HZ_ERR;
      end
    endcase
  end

  // State, timeout counter and deferred-flush flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HZ_RUN;
      to_cnt_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.freeze_PC     = freeze_s;
  assign bus.freeze_IF_ID  = freeze_s;
  assign bus.bubble_ID_EXE = bubble_s;
  assign bus.flush_IF_ID   = flush_s;
  assign bus.stall_all     = stall_s;
  assign bus.timeout_err   = err_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    if (en && (cnt != 32'hFFFF_FFFF)) begin
      return cnt + 32'd1;
    end else begin
      return cnt;
    end
  endfunction

  // Saturating event counters for hazard stalls, memory stalls and flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt_q    <= 32'd0;
      mem_cnt_q   <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      lu_cnt_q    <= sat_inc(lu_cnt_q, bubble_s & ~flush_s);
      mem_cnt_q   <= sat_inc(mem_cnt_q, stall_s);
      flush_cnt_q <= sat_inc(flush_cnt_q, flush_s);
    end
  end

  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MEM_TIMEOUT=4). Expected output
// vectors {freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, stall_all,
// timeout_err} are queued with each stimulus and popped when sampled.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) bus ();

  hazard_stall_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .TO_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  string      tag_q[$];
  logic [5:0] exp_q[$];

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_FRZ   = 6'b111000;
  localparam logic [5:0] O_FLUSH = 6'b001100;
  localparam logic [5:0] O_STALL = 6'b000010;
  localparam logic [5:0] O_ERR   = 6'b000011;

  task automatic idle();
    bus.fwd_en = 1'b1; bus.src1_ID = 5'd0; bus.src2_ID = 5'd0; bus.two_src_ID = 1'b0;
    bus.dest_EXE = 5'd0; bus.WB_EN_EXE = 1'b0; bus.MEM_R_EN_EXE = 1'b0;
    bus.dest_MEM = 5'd0; bus.WB_EN_MEM = 1'b0; bus.branch_taken_EXE = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; samples mid-low-phase.
  task automatic chk(input string tag, input logic [5:0] exp);
    string      t;
    logic [5:0] e;
    logic [5:0] o;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    #2;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    o = {bus.freeze_PC, bus.freeze_IF_ID, bus.bubble_ID_EXE,
         bus.flush_IF_ID, bus.stall_all, bus.timeout_err};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", t, o, e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("reset", O_NONE);
    rst = 1'b1;
    chk("idle", O_NONE);

    // Load-use with forwarding: one-cycle freeze.
    bus.MEM_R_EN_EXE = 1'b1; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd4; bus.src1_ID = 5'd4;
    chk("lu_fwd", O_FRZ);
    bus.MEM_R_EN_EXE = 1'b0; bus.WB_EN_EXE = 1'b0; bus.dest_EXE = 5'd0;
    bus.dest_MEM = 5'd4; bus.WB_EN_MEM = 1'b1;
    chk("lu_fwd_next", O_NONE);

    // No forwarding: ALU RAW held through EXE and MEM.
    idle(); bus.fwd_en = 1'b0;
    bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd5; bus.src2_ID = 5'd5; bus.two_src_ID = 1'b1;
    chk("nofwd_exe", O_FRZ);
    bus.WB_EN_EXE = 1'b0; bus.dest_EXE = 5'd0; bus.dest_MEM = 5'd5; bus.WB_EN_MEM = 1'b1;
    chk("nofwd_mem", O_FRZ);
    bus.WB_EN_MEM = 1'b0; bus.dest_MEM = 5'd0;
    chk("nofwd_done", O_NONE);

    // Match-rule boundaries.
    idle(); bus.fwd_en = 1'b0; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd0; bus.src1_ID = 5'd0;
    chk("dest_zero", O_NONE);
    bus.dest_EXE = 5'd6; bus.src1_ID = 5'd1; bus.src2_ID = 5'd6; bus.two_src_ID = 1'b0;
    chk("src2_unused", O_NONE);
    bus.two_src_ID = 1'b1;
    chk("src2_used", O_FRZ);
    idle(); bus.MEM_R_EN_EXE = 1'b1; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd7;
    bus.src1_ID = 5'd8; bus.src2_ID = 5'd9; bus.two_src_ID = 1'b1;
    chk("lu_nomatch", O_NONE);
    idle(); bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd7; bus.src1_ID = 5'd7;
    chk("alu_fwd", O_NONE);

    // Three-cycle memory wait, hazard inputs masked while stalled.
    idle(); bus.mem_req = 1'b1;
    chk("mem_w0", O_STALL);
    bus.MEM_R_EN_EXE = 1'b1; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd3; bus.src1_ID = 5'd3;
    chk("mem_w1", O_STALL);
    chk("mem_w2", O_STALL);
    idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    chk("mem_rdy", O_NONE);
    idle();
    chk("run_after", O_NONE);
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    chk("mem_hit", O_NONE);
    bus.mem_req = 1'b0;
    chk("rdy_noreq", O_NONE);

    // Branch during memory wait is deferred to the first RUN cycle.
    idle(); bus.mem_req = 1'b1;
    chk("br_w0", O_STALL);
    bus.branch_taken_EXE = 1'b1;
    chk("br_w1", O_STALL);
    bus.branch_taken_EXE = 1'b0;
    chk("br_w2", O_STALL);
    bus.mem_ready = 1'b1;
    chk("br_rdy", O_NONE);
    idle();
    chk("pend_flush", O_FLUSH);
    chk("pend_clear", O_NONE);

    // Branch beats a simultaneous load-use hazard.
    bus.branch_taken_EXE = 1'b1;
    bus.MEM_R_EN_EXE = 1'b1; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 5'd2; bus.src1_ID = 5'd2;
    chk("br_vs_lu", O_FLUSH);
    idle();
    chk("br_done", O_NONE);

    // Timeout: five stall cycles, then sticky ERR.
    bus.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) chk("to_wait", O_STALL);
    chk("to_err", O_ERR);
    bus.mem_req = 1'b0; bus.mem_ready = 1'b1;
    chk("err_sticky", O_ERR);
    chk("err_sticky2", O_ERR);

    // Asynchronous reset clears ERR without a clock edge.
    idle(); rst = 1'b0;
    chk("err_rst", O_NONE);
    rst = 1'b1;
    chk("err_rst_rel", O_NONE);

    // Reset mid-wait discards the pending flush.
    bus.mem_req = 1'b1; bus.branch_taken_EXE = 1'b1;
    chk("rw_w0", O_STALL);
    bus.branch_taken_EXE = 1'b0;
    chk("rw_w1", O_STALL);
    idle(); rst = 1'b0;
    chk("rw_rst", O_NONE);
    rst = 1'b1;
    chk("rw_no_flush", O_NONE);
    chk("rw_no_flush2", O_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
